// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order memory-op issue queue with operand capture and
// two-bus tag wakeup; head issues to the AGU once both operands are ready.
`default_nettype none

`ifndef INST_STATE_WD
`define INST_STATE_WD 4
`endif

module mem_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  // dispatch side
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [11:0]               in_op,
  input  logic [`INST_STATE_WD-1:0] in_status,
  input  logic [TAG_W-1:0]          in_src1_tag,
  input  logic [TAG_W-1:0]          in_src2_tag,
  input  logic                      in_src1_rdy,
  input  logic                      in_src2_rdy,
  input  logic [31:0]               in_src1_val,
  input  logic [31:0]               in_src2_val,
  // wakeup buses
  input  logic                      wb0_valid,
  input  logic [TAG_W-1:0]          wb0_tag,
  input  logic [31:0]               wb0_data,
  input  logic                      wb1_valid,
  input  logic [TAG_W-1:0]          wb1_tag,
  input  logic [31:0]               wb1_data,
  // issue side
  output logic                      ready,
  output logic [11:0]               op,
  output logic [`INST_STATE_WD-1:0] inst_status,
  output logic [31:0]               rdata1,
  output logic [31:0]               rdata2,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   head_ptr;
  logic [AW:0]   tail_ptr;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic          full;
  logic          enq_fire;
  logic          deq_fire;
  logic          is_load;

  logic [DEPTH-1:0]          e_valid;
  logic [DEPTH-1:0]          e_rdy1;
  logic [DEPTH-1:0]          e_rdy2;
  logic [11:0]               e_op     [DEPTH];
  logic [`INST_STATE_WD-1:0] e_status [DEPTH];
  logic [TAG_W-1:0]          e_tag1   [DEPTH];
  logic [TAG_W-1:0]          e_tag2   [DEPTH];
  logic [31:0]               e_val1   [DEPTH];
  logic [31:0]               e_val2   [DEPTH];

  logic        cap1_rdy;
  logic        cap2_rdy;
  logic [31:0] cap1_val;
  logic [31:0] cap2_val;

  assign head_idx = head_ptr[AW-1:0];
  assign tail_idx = tail_ptr[AW-1:0];
  assign full     = (head_ptr[AW] != tail_ptr[AW]) && (head_idx == tail_idx);
  assign count    = tail_ptr - head_ptr;
  assign in_ready = !full && !flush;
  assign is_load  = |in_op[7:3];
  assign enq_fire = in_valid && in_ready && (|in_op[7:0]);

  assign ready    = e_valid[head_idx] && e_rdy1[head_idx] && e_rdy2[head_idx] && !flush;
  assign deq_fire = ready;

  // Enqueue-time operand capture: direct value, else same-cycle bus hit (wb0 first).
  always_comb begin
    cap1_rdy = 1'b0;
    cap1_val = in_src1_val;
    if (in_src1_rdy) begin
      cap1_rdy = 1'b1;
    end else if (wb0_valid && (wb0_tag == in_src1_tag)) begin
      cap1_rdy = 1'b1;
      cap1_val = wb0_data;
    end else if (wb1_valid && (wb1_tag == in_src1_tag)) begin
      cap1_rdy = 1'b1;
      cap1_val = wb1_data;
    end

    cap2_rdy = 1'b0;
    cap2_val = in_src2_val;
    if (in_src2_rdy || is_load) begin
      cap2_rdy = 1'b1;
    end else if (wb0_valid && (wb0_tag == in_src2_tag)) begin
      cap2_rdy = 1'b1;
      cap2_val = wb0_data;
    end else if (wb1_valid && (wb1_tag == in_src2_tag)) begin
      cap2_rdy = 1'b1;
      cap2_val = wb1_data;
    end
  end

  always_comb begin
    op          = '0;
    inst_status = '0;
    rdata1      = '0;
    rdata2      = '0;
    if (ready) begin
      op          = e_op[head_idx];
      inst_status = e_status[head_idx];
      rdata1      = e_val1[head_idx];
      rdata2      = e_val2[head_idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      e_valid  <= '0;
      e_rdy1   <= '0;
      e_rdy2   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_op[i]     <= '0;
        e_status[i] <= '0;
        e_tag1[i]   <= '0;
        e_tag2[i]   <= '0;
        e_val1[i]   <= '0;
        e_val2[i]   <= '0;
      end
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      e_valid  <= '0;
      e_rdy1   <= '0;
      e_rdy2   <= '0;
    end else begin
      // Wakeup of pending operands already resident in the queue.
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && !e_rdy1[i]) begin
          if (wb0_valid && (wb0_tag == e_tag1[i])) begin
            e_rdy1[i] <= 1'b1;
            e_val1[i] <= wb0_data;
          end else if (wb1_valid && (wb1_tag == e_tag1[i])) begin
            e_rdy1[i] <= 1'b1;
            e_val1[i] <= wb1_data;
          end
        end
        if (e_valid[i] && !e_rdy2[i]) begin
          if (wb0_valid && (wb0_tag == e_tag2[i])) begin
            e_rdy2[i] <= 1'b1;
            e_val2[i] <= wb0_data;
          end else if (wb1_valid && (wb1_tag == e_tag2[i])) begin
            e_rdy2[i] <= 1'b1;
            e_val2[i] <= wb1_data;
          end
        end
      end

      if (deq_fire) begin
        e_valid[head_idx] <= 1'b0;
        head_ptr          <= head_ptr + 1'b1;
      end

      // Tail slot is never valid when enqueue fires, so it cannot collide with a wakeup.
      if (enq_fire) begin
        e_valid[tail_idx]  <= 1'b1;
        e_op[tail_idx]     <= in_op;
        e_status[tail_idx] <= in_status;
        e_tag1[tail_idx]   <= in_src1_tag;
        e_tag2[tail_idx]   <= in_src2_tag;
        e_rdy1[tail_idx]   <= cap1_rdy;
        e_rdy2[tail_idx]   <= cap2_rdy;
        e_val1[tail_idx]   <= cap1_val;
        e_val2[tail_idx]   <= cap2_val;
        tail_ptr           <= tail_ptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_issue_queue.md
MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 6, width of physical source tags.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all entries.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), dispatch handshake.
REQ-007 SHALL have ports in_op (input, 12) and in_status (input, `INST_STATE_WD), memory op one-hot {4 unused, lb, lbu, lh, lhu, lw, sb, sh, sw} and instruction status.
REQ-008 SHALL have ports in_src1_tag/in_src2_tag (input, TAG_W), in_src1_rdy/in_src2_rdy (input, 1), in_src1_val/in_src2_val (input, 32): base and store-data operands.
REQ-009 SHALL have two wakeup buses wb0_/wb1_: valid (input, 1), tag (input, TAG_W), data (input, 32).
REQ-010 SHALL have port ready (output, 1), issue strobe to the AGU stage.
REQ-011 SHALL have ports op (output, 12), inst_status (output, `INST_STATE_WD), rdata1/rdata2 (output, 32): issued head entry.
REQ-012 SHALL have port count (output, $clog2(DEPTH)+1), current occupancy.

Function
REQ-013 SHALL be a circular FIFO; head/tail pointers with extra wrap bit; full = pointers equal except wrap bit; empty = pointers equal.
REQ-014 SHALL assert in_ready = (count < DEPTH) & !flush, independent of same-cycle issue (no full-queue pass-through).
REQ-015 SHALL enqueue at tail when in_valid & in_ready & |in_op[7:0]; in_valid with in_op[7:0]==0 dropped, no entry written.
REQ-016 SHALL capture each operand at enqueue: in_srcN_rdy=1 -> in_srcN_val; else tag match on valid wakeup bus same cycle -> bus data, marked ready; else marked pending with tag stored.
REQ-017 SHALL, every cycle, compare tag of each pending operand in each valid entry against both buses; on match latch data and mark ready at next edge.
REQ-018 SHALL give wb0 priority over wb1 when both match the same operand in the same cycle.
REQ-019 SHALL treat src2 as ready for loads (in_op[7:3] nonzero) regardless of in_src2_rdy.
REQ-020 SHALL drive ready combinationally = head valid & src1 ready & src2 ready & !flush; issue strictly in order, never bypassing a blocked head.
REQ-021 SHALL pop head on the cycle ready=1; outputs op/inst_status/rdata1/rdata2 SHALL equal head entry when ready=1 and all-zero otherwise.
REQ-022 SHALL have latency: entry enqueued at edge N with operands ready -> ready=1 in cycle N+1 earliest; wakeup in cycle M -> ready earliest in cycle M+1.
REQ-023 SHALL support enqueue and issue in the same cycle; count unchanged then.
REQ-024 SHALL, on flush=1, invalidate all entries and zero pointers/count at next edge; ready=0 and enqueue blocked in that cycle; wakeups ignored.
REQ-025 SHALL increment pointers modulo 2*DEPTH, index = low $clog2(DEPTH) bits.

Reset
REQ-026 SHALL, while resetn=0 (asynchronously), clear all entry valid/ready bits, pointers to 0, count=0, ready=0, op/inst_status/rdata1/rdata2=0.
REQ-027 SHALL assert in_ready=1 in first cycle after resetn deasserts (flush=0).
REQ-028 SHALL discard in-flight entries on reset mid-operation; no issue after release until new enqueue.

Verification
REQ-029 Enqueue lw, in_src1_rdy=1, val=0x1000 -> next cycle ready=1, op=12'h008, rdata1=0x1000; count 1->0.
REQ-030 Enqueue sw, src1 ready 0x2000, src2 pending tag 5; wb1 tag 5 data 0xDEADBEEF two cycles later -> ready=1 cycle after wakeup, rdata2=0xDEADBEEF.
REQ-031 Fill 4 entries, head pending, entries 2-4 ready -> in_ready=0, ready=0, no younger issue; wake head -> four issues in program order on consecutive cycles.
REQ-032 wb0 and wb1 both tag 3, data 0x11/0x22, pending src1 tag 3 -> captured 0x11.
REQ-033 Three entries queued, flush pulse with in_valid=1 -> ready=0 that cycle, count=0 next cycle, incoming op not enqueued.
REQ-034 Async resetn low mid-cycle with 2 entries -> outputs zero immediately, count=0; after release in_ready=1, ready=0; 9 enq/issue pairs verify pointer wrap with in-order data.
